led_pattern_controller: RTL and testbench
=========================================

// Module: led_pattern_controller
//
// PURPOSE
// Drives the Basys3 LED bank from the slide switches and one pushbutton. It
// sequences the LEDs through three display modes: MIRROR, BLINK and CHASE.
// The block synchronizes and debounces every board input. The pushbutton
// steps the mode. A step-rate timer paces the animated modes. This block
// replaces a direct switch-to-LED wire in the top level.
//
// PARAMETERS
// N_LEDS           6           number of switch inputs and LED outputs
// DEBOUNCE_CYCLES  1_000_000   consecutive stable cycles needed to accept an
//                              input change (10 ms at 100 MHz), must be >= 1
// STEP_CYCLES      25_000_000  clock cycles per animation step
//                              (0.25 s at 100 MHz), must be >= 2
//
// PORTS
// i_clk       in   1       system clock (100 MHz board clock)
// i_rst       in   1       reset, asynchronous, active-high
// i_switch    in   N_LEDS  raw slide switches, asynchronous to i_clk
// i_mode_btn  in   1       raw pushbutton, asynchronous, high = pressed
// o_led       out  N_LEDS  LED drive, registered, high = lit
// o_mode      out  2       current mode: 0 = MIRROR, 1 = BLINK, 2 = CHASE
//
// BEHAVIOUR
// - One clock and one reset. i_rst is asynchronous and active-high.
// - Reset values: o_led = 0 and o_mode = 0 (MIRROR). Sync flops, debounced
//   values and all counters reset to 0. blink_phase resets to 1. chase
//   resets to 1 (bit 0).
// - Reset mid-operation: asserting i_rst clears all state at once. After
//   release the block behaves exactly as it does from power-up.
// - Synchronizer: each raw input passes through a 2-flop synchronizer.
// - Debounce: each bit has its own counter.
//   - On a cycle where the synced value differs from the stable value, the
//     counter increments.
//   - On a cycle where they are equal, the counter clears.
//   - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the stable
//     value takes the synced value and the counter clears.
//   - Pulses shorter than DEBOUNCE_CYCLES are ignored.
// - Button event: a one-cycle pulse on each 0->1 transition of the
//   debounced button. A release produces no event.
// - Mode FSM:
//   - Transitions on a button event: MIRROR -> BLINK -> CHASE -> MIRROR.
//   - Unused code 3 goes to MIRROR on the next clock.
//   - o_mode is the FSM state register.
// - Step timer:
//   - Counts 0 .. STEP_CYCLES-1.
//   - Emits a one-cycle tick when the count is STEP_CYCLES-1, then wraps
//     to 0.
//   - Clears to 0 on every mode change.
// - On mode entry: blink_phase = 1 and chase = 1.
// - MIRROR: o_led = debounced switches.
// - BLINK:
//   - blink_phase toggles on each tick.
//   - o_led = debounced switches while blink_phase = 1, otherwise 0.
//   - The LEDs are on for the first STEP_CYCLES cycles after entry.
// - CHASE:
//   - o_led = chase, a one-hot vector that rotates left by one on each tick.
//   - Bit N_LEDS-1 wraps to bit 0.
//   - Switches are ignored.
// - Simultaneous button event and tick: the mode change wins. The tick is
//   discarded, and the entry values and timer clear apply.
// - Latency:
//   - Pin to debounced value: 2 + DEBOUNCE_CYCLES cycles.
//   - Debounced value to o_led: 1 cycle, so MIRROR total = DEBOUNCE_CYCLES + 3.
//   - Button event to o_mode: 1 cycle.
//   - Button event to new o_led pattern: 2 cycles.
//
// TESTING (DEBOUNCE_CYCLES = 4, STEP_CYCLES = 8)
// 1. Reset: hold i_rst with random inputs -> o_led = 0 and o_mode = 0 during
//    reset and on the first cycle after release.
// 2. MIRROR: step i_switch to 6'b101101 -> o_led = 6'b101101 exactly 7 cycles
//    later. A 3-cycle glitch to 6'b000000 -> o_led unchanged.
// 3. Press the button (held 10 cycles, switches = 6'b101101) -> o_mode = 1.
//    o_led then repeats 6'b101101 for 8 cycles and 6'b000000 for 8 cycles.
//    Releasing the button causes no mode change.
// 4. Second press -> o_mode = 2. o_led steps 000001, 000010, ..., 100000,
//    000001, holding each value for 8 cycles and wrapping correctly.
// 5. Third press timed to land on the tick cycle -> o_mode = 0, o_led =
//    switches, and no extra chase step. A button bounce shorter than 4
//    cycles causes no mode change.
// 6. Assert i_rst mid-CHASE (o_led = 6'b000100) -> o_led = 0 and o_mode = 0
//    with no clock edge. After release, MIRROR timing matches test 2.

Source files
------------

// File: rtl/led_pattern_controller.sv
// Purpose: board-input conditioning plus MIRROR/BLINK/CHASE LED sequencer for the Basys3 LED bank.
// Latency: pin->debounced 2+DEBOUNCE_CYCLES, debounced->o_led 1, button event->o_mode 1, ->o_led 2.
// Backpressure: none; free-running outputs, every input is sampled every cycle.
module led_pattern_controller #(
  parameter int N_LEDS          = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 25_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_LEDS-1:0] i_switch,
  input  logic              i_mode_btn,
  output logic [N_LEDS-1:0] o_led,
  output logic [1:0]        o_mode
);

  // The button rides along as the top bit of the switch vector through sync/debounce.
  localparam int NB = N_LEDS + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  localparam logic [1:0] MODE_MIRROR = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;

  logic [NB-1:0]     raw;
  logic [NB-1:0]     sync1;
  logic [NB-1:0]     sync2;
  logic [NB-1:0]     stable;
  logic [DW-1:0]     db_cnt [NB];
  logic              btn_prev;
  logic              btn_evt;
  logic [N_LEDS-1:0] sw_db;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              mode_change;
  logic              tick;
  logic [SW-1:0]     step_cnt;
  logic              blink_phase;
  logic [N_LEDS-1:0] chase;
  logic [N_LEDS-1:0] led_next;

  assign raw    = {i_mode_btn, i_switch};
  assign sw_db  = stable[N_LEDS-1:0];
  assign o_mode = state;

  // Two-flop synchronizer for every asynchronous board input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stable <= '0;
      for (int b = 0; b < NB; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (sync2[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db_cnt[b] <= '0;
          stable[b] <= sync2[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Remember the previous debounced button level for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= stable[N_LEDS];
    end
  end

  // Press (0->1) of the debounced button is the only mode-step event; release is ignored.
  assign btn_evt = stable[N_LEDS] & ~btn_prev;

  // Mode FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= MODE_MIRROR;
    end else begin
      state <= state_next;
    end
  end

  // Mode FSM next state: cycle on each press, recover from the unused code.
  always_comb begin
    state_next = state;
    case (state)
      MODE_MIRROR: if (btn_evt) state_next = MODE_BLINK;
      MODE_BLINK:  if (btn_evt) state_next = MODE_CHASE;
      MODE_CHASE:  if (btn_evt) state_next = MODE_MIRROR;
      default:     state_next = MODE_MIRROR;
    endcase
  end

  // Mode FSM outputs: change strobe, step tick and the LED pattern for the current mode.
  always_comb begin
    mode_change = (state_next != state);
    tick        = (step_cnt == STEP_LAST);
    led_next    = '0;
    case (state)
      MODE_MIRROR: led_next = sw_db;
      MODE_BLINK:  led_next = blink_phase ? sw_db : '0;
      MODE_CHASE:  led_next = chase;
      default:     led_next = '0;
    endcase
  end

  // Step timer; a mode change restarts it so every mode begins with a full step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_cnt <= '0;
    end else if (mode_change || tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Animation state: entry values on mode change (which wins over a coincident tick), else advance on tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_phase <= 1'b1;
      chase       <= N_LEDS'(1);
    end else if (mode_change) begin
      blink_phase <= 1'b1;
      chase       <= N_LEDS'(1);
    end else if (tick) begin
      if (state == MODE_BLINK) begin
        blink_phase <= ~blink_phase;
      end
      if (state == MODE_CHASE) begin
        chase <= {chase[N_LEDS-2:0], chase[N_LEDS-1]};
      end
    end
  end

  // Registered LED drive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_led <= '0;
    end else begin
      o_led <= led_next;
    end
  end

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with DEBOUNCE_CYCLES = 4, STEP_CYCLES = 8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_led_pattern_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sw;
  logic       btn;
  logic [5:0] led;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] PAT = 6'b101101;

  led_pattern_controller #(
    .N_LEDS         (6),
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_switch  (sw),
    .i_mode_btn(btn),
    .o_led     (led),
    .o_mode    (mode)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_led;
    logic [1:0] exp_mode;

    // Reset held with random inputs.
    rst = 1'b1;
    sw  = '0;
    btn = 1'b0;
    #1;
    check("rst_led_t0", 8'(led), 8'd0);
    check("rst_mode_t0", 8'(mode), 8'd0);
    for (int i = 0; i < 5; i++) begin
      sw  = 6'($urandom);
      btn = 1'($urandom);
      step(1);
      check("rst_led", 8'(led), 8'd0);
      check("rst_mode", 8'(mode), 8'd0);
    end
    sw  = '0;
    btn = 1'b0;
    rst = 1'b0;
    step(1);
    check("post_rst_led", 8'(led), 8'd0);
    check("post_rst_mode", 8'(mode), 8'd0);
    step(3);

    // MIRROR latency: new switch value appears on o_led exactly 7 cycles later.
    sw = PAT;
    for (int n = 1; n <= 7; n++) begin
      step(1);
      exp_led = (n == 7) ? PAT : 6'b000000;
      check("mirror_latency", 8'(led), 8'(exp_led));
    end
    // 3-cycle glitch to zero is filtered.
    sw = 6'b000000;
    step(3);
    sw = PAT;
    for (int n = 1; n <= 12; n++) begin
      step(1);
      check("mirror_glitch", 8'(led), 8'(PAT));
    end

    // First press: BLINK, 8 cycles on / 8 cycles off; release causes nothing.
    btn = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      exp_mode = (n >= 7) ? 2'd1 : 2'd0;
      if (n < 16) exp_led = PAT;
      else exp_led = ((((n - 16) / 8) % 2) == 0) ? 6'b000000 : PAT;
      check("blink_mode", 8'(mode), 8'(exp_mode));
      check("blink_led", 8'(led), 8'(exp_led));
      if (n == 10) btn = 1'b0;
    end

    // Second press: CHASE, one-hot rotating left every 8 cycles with wrap.
    btn = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      step(1);
      exp_mode = (n >= 7) ? 2'd2 : 2'd1;
      check("chase_mode", 8'(mode), 8'(exp_mode));
      if (n >= 8) begin
        exp_led = 6'b000001 << (((n - 8) / 8) % 6);
        check("chase_led", 8'(led), 8'(exp_led));
      end
      if (n == 10) btn = 1'b0;
    end

    // Third press lands on the tick cycle: back to MIRROR, no extra chase step shown.
    btn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      exp_mode = (n >= 7) ? 2'd0 : 2'd2;
      exp_led  = (n <= 7) ? 6'b000010 : PAT;
      check("tick_press_mode", 8'(mode), 8'(exp_mode));
      check("tick_press_led", 8'(led), 8'(exp_led));
      if (n == 10) btn = 1'b0;
    end

    // Button bounce shorter than the debounce window.
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step(1);
      check("bounce_mode", 8'(mode), 8'd0);
      check("bounce_led", 8'(led), 8'(PAT));
    end

    // Back into CHASE, then reset mid-pattern.
    btn = 1'b1;
    step(10);
    btn = 1'b0;
    step(10);
    check("to_blink_mode", 8'(mode), 8'd1);
    btn = 1'b1;
    step(10);
    btn = 1'b0;
    step(10);
    step(4);
    check("mid_chase_led", 8'(led), 8'b000100);
    check("mid_chase_mode", 8'(mode), 8'd2);
    rst = 1'b1;
    #2;
    check("async_rst_led", 8'(led), 8'd0);
    check("async_rst_mode", 8'(mode), 8'd0);
    #1;
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step(1);
      exp_led = (n == 7) ? PAT : 6'b000000;
      check("rerst_mirror_led", 8'(led), 8'(exp_led));
      check("rerst_mirror_mode", 8'(mode), 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
